// File: rtl/trashbin_mem_fabric.sv
// trashbin_mem_fabric
// Memory fabric between the TrashbinCore memory bus and NUM_SLAVES slaves.
// One access at a time: the address is decoded to a slave index, the slave
// is held selected until it reports ready (or the access times out), then a
// single OK pulse is returned to the core. Unmapped addresses and timeouts
// complete with ERR_DATA on reads and set a sticky error flag. A startup
// window after reset keeps the core off the bus. Debug state (last address,
// transaction count, error flag) is exported for LEDs and the hex display.
module trashbin_mem_fabric #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int NUM_SLAVES     = 4,
  parameter int SEL_LSB        = 14,
  parameter int SEL_W          = 2,
  parameter int STARTUP_CYCLES = 16,
  parameter int TIMEOUT_CYCLES = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEADBEEF)
) (
  input  logic                         CoreClock,
  input  logic                         ResetN,
  input  logic                         CoreReq,
  input  logic                         CoreWrite,
  input  logic [ADDR_W-1:0]            CoreAddress,
  input  logic [DATA_W-1:0]            CoreWData,
  output logic [DATA_W-1:0]            CoreRData,
  output logic                         CoreReadOK,
  output logic                         CoreWriteOK,
  output logic [NUM_SLAVES-1:0]        SlaveSel,
  output logic                         SlaveWe,
  output logic [SEL_LSB-1:0]           SlaveAddr,
  output logic [DATA_W-1:0]            SlaveWData,
  input  logic [NUM_SLAVES*DATA_W-1:0] SlaveRData,
  input  logic [NUM_SLAVES-1:0]        SlaveReady,
  output logic                         StartupDone,
  output logic [ADDR_W-1:0]            LastAddress,
  output logic [15:0]                  TxnCount,
  output logic                         ErrorFlag
);

  // Counter widths sized so the terminal values fit.
  localparam int BOOT_W = $clog2(STARTUP_CYCLES + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(STARTUP_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

  // Fabric states.
  localparam logic [1:0] StBoot   = 2'd0;
  localparam logic [1:0] StIdle   = 2'd1;
  localparam logic [1:0] StAccess = 2'd2;
  localparam logic [1:0] StResp   = 2'd3;

  logic [1:0]        stateReg;
  logic [1:0]        stateNext;
  logic [BOOT_W-1:0] bootCountReg;
  logic [TO_W-1:0]   timeoutCountReg;
  logic              startupDoneReg;

  // Latched access, captured when a request is accepted in IDLE.
  logic [ADDR_W-1:0] lastAddressReg;
  logic              latchWriteReg;
  logic [DATA_W-1:0] latchWDataReg;
  logic [SEL_W-1:0]  latchIdxReg;
  logic              respErrReg;

  logic [DATA_W-1:0] rdataReg;
  logic [15:0]       txnCountReg;
  logic              errorFlagReg;

  // Decode of the incoming request and of the selected slave's response.
  logic [SEL_W-1:0]  reqIdx;
  logic              reqMapped;
  logic              selReady;
  logic [DATA_W-1:0] selData;

  // Per-cycle events that drive every register below.
  logic bootDone;
  logic acceptReq;
  logic accessHit;
  logic accessTimeout;
  logic respDone;

  assign reqIdx    = CoreAddress[SEL_LSB +: SEL_W];
  assign reqMapped = (32'(reqIdx) < NUM_SLAVES);

  // Pick the ready bit and read data of the slave chosen by the latched index.
  always_comb begin
    selReady = 1'b0;
    selData  = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (latchIdxReg == SEL_W'(i)) begin
        selReady = SlaveReady[i];
        selData  = SlaveRData[i*DATA_W +: DATA_W];
      end
    end
  end

  // Event decode: ready takes priority over a timeout on the same cycle.
  always_comb begin
    bootDone      = (stateReg == StBoot) && (bootCountReg == BOOT_LAST);
    acceptReq     = (stateReg == StIdle) && CoreReq;
    accessHit     = (stateReg == StAccess) && selReady;
    accessTimeout = (stateReg == StAccess) && !selReady && (timeoutCountReg == TO_LAST);
    respDone      = (stateReg == StResp);
  end

  // Next-state logic for the access sequencer.
  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      StBoot:   if (bootDone) stateNext = StIdle;
      StIdle:   if (acceptReq) stateNext = reqMapped ? StAccess : StResp;
      StAccess: if (accessHit || accessTimeout) stateNext = StResp;
      StResp:   stateNext = StIdle;
      default:  stateNext = StBoot;
    endcase
  end

  // State register; reset abandons any access in flight.
  always_ff @(posedge CoreClock or negedge ResetN) begin
    if (!ResetN) begin
      stateReg <= StBoot;
    end else begin
      stateReg <= stateNext;
    end
  end

  // Startup window counter and the sticky StartupDone flag.
  always_ff @(posedge CoreClock or negedge ResetN) begin
    if (!ResetN) begin
      bootCountReg   <= '0;
      startupDoneReg <= 1'b0;
    end else if (stateReg == StBoot) begin
      if (bootDone) begin
        startupDoneReg <= 1'b1;
      end else begin
        bootCountReg <= bootCountReg + BOOT_W'(1);
      end
    end
  end

  // Access timeout counter: cleared on accept, counts every ACCESS cycle.
  always_ff @(posedge CoreClock or negedge ResetN) begin
    if (!ResetN) begin
      timeoutCountReg <= '0;
    end else if (acceptReq) begin
      timeoutCountReg <= '0;
    end else if ((stateReg == StAccess) && !accessHit && !accessTimeout) begin
      timeoutCountReg <= timeoutCountReg + TO_W'(1);
    end
  end

  // Latch the request so the slave sees stable signals for the whole access.
  always_ff @(posedge CoreClock or negedge ResetN) begin
    if (!ResetN) begin
      lastAddressReg <= '0;
      latchWriteReg  <= 1'b0;
      latchWDataReg  <= '0;
      latchIdxReg    <= '0;
    end else if (acceptReq) begin
      lastAddressReg <= CoreAddress;
      latchWriteReg  <= CoreWrite;
      latchWDataReg  <= CoreWData;
      latchIdxReg    <= reqIdx;
    end
  end

  // Completion status carried into RESP: unmapped or timed out means error.
  always_ff @(posedge CoreClock or negedge ResetN) begin
    if (!ResetN) begin
      respErrReg <= 1'b0;
    end else if (acceptReq) begin
      respErrReg <= !reqMapped;
    end else if (accessHit) begin
      respErrReg <= 1'b0;
    end else if (accessTimeout) begin
      respErrReg <= 1'b1;
    end
  end

  // Read data register: loaded only when a read enters RESP, held otherwise.
  always_ff @(posedge CoreClock or negedge ResetN) begin
    if (!ResetN) begin
      rdataReg <= '0;
    end else if (acceptReq && !reqMapped && !CoreWrite) begin
      rdataReg <= ERR_DATA;
    end else if (accessHit && !latchWriteReg) begin
      rdataReg <= selData;
    end else if (accessTimeout && !latchWriteReg) begin
      rdataReg <= ERR_DATA;
    end
  end

  // Debug counters: every completed access counts, errors stick until reset.
  always_ff @(posedge CoreClock or negedge ResetN) begin
    if (!ResetN) begin
      txnCountReg  <= '0;
      errorFlagReg <= 1'b0;
    end else if (respDone) begin
      txnCountReg <= txnCountReg + 16'd1;
      if (respErrReg) begin
        errorFlagReg <= 1'b1;
      end
    end
  end

  // One-hot slave select, decoded straight from state so reset drops it at once.
  generate
    for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_sel
      assign SlaveSel[gi] = (stateReg == StAccess) && (latchIdxReg == SEL_W'(gi));
    end
  endgenerate

  assign SlaveWe     = (stateReg == StAccess) && latchWriteReg;
  assign SlaveAddr   = lastAddressReg[SEL_LSB-1:0];
  assign SlaveWData  = latchWDataReg;

  assign CoreReadOK  = (stateReg == StResp) && !latchWriteReg;
  assign CoreWriteOK = (stateReg == StResp) && latchWriteReg;
  assign CoreRData   = rdataReg;

  assign StartupDone = startupDoneReg;
  assign LastAddress = lastAddressReg;
  assign TxnCount    = txnCountReg;
  assign ErrorFlag   = errorFlagReg;

endmodule

// File: tb/tb_trashbin_mem_fabric.sv
// tb_trashbin_mem_fabric
// Randomized bench with a transaction-level reference model. Each access is
// described by its start cycle, slave index and ready delay; the model
// derives from those when every output must change. A single compare process
// checks all outputs on every falling edge, and a few hand-computed
// expectations pin the model to known numbers.
module tb_trashbin_mem_fabric;

  localparam int NS = 3;
  localparam int TO = 8;
  localparam int SU = 16;
  localparam logic [31:0] ERRD = 32'hDEADBEEF;

  logic        CoreClock = 1'b0;
  logic        ResetN;
  logic        CoreReq;
  logic        CoreWrite;
  logic [31:0] CoreAddress;
  logic [31:0] CoreWData;
  logic [31:0] CoreRData;
  logic        CoreReadOK;
  logic        CoreWriteOK;
  logic [2:0]  SlaveSel;
  logic        SlaveWe;
  logic [13:0] SlaveAddr;
  logic [31:0] SlaveWData;
  logic [95:0] SlaveRData;
  logic [2:0]  SlaveReady;
  logic        StartupDone;
  logic [31:0] LastAddress;
  logic [15:0] TxnCount;
  logic        ErrorFlag;

  trashbin_mem_fabric #(
    .ADDR_W(32), .DATA_W(32), .NUM_SLAVES(NS), .SEL_LSB(14), .SEL_W(2),
    .STARTUP_CYCLES(SU), .TIMEOUT_CYCLES(TO), .ERR_DATA(ERRD)
  ) dut (
    .CoreClock(CoreClock), .ResetN(ResetN),
    .CoreReq(CoreReq), .CoreWrite(CoreWrite), .CoreAddress(CoreAddress), .CoreWData(CoreWData),
    .CoreRData(CoreRData), .CoreReadOK(CoreReadOK), .CoreWriteOK(CoreWriteOK),
    .SlaveSel(SlaveSel), .SlaveWe(SlaveWe), .SlaveAddr(SlaveAddr), .SlaveWData(SlaveWData),
    .SlaveRData(SlaveRData), .SlaveReady(SlaveReady),
    .StartupDone(StartupDone), .LastAddress(LastAddress), .TxnCount(TxnCount), .ErrorFlag(ErrorFlag)
  );

  always #5 CoreClock = ~CoreClock;

  // Model state.
  int          cyc = 0;
  int          relCyc = 0;
  bit          inReset;
  bit          txActive;
  int          txN, txR, txIdx, txReadyCyc, txCount;
  bit          txWr, txMapped, txErr;
  logic [31:0] txAddr, txWData, txData;
  bit          pendCommit;
  int          pendCyc;
  bit          pendErr;
  logic [31:0] mdlRData, mdlLast;
  logic [15:0] mdlTxn;
  bit          mdlErr;

  // Expected outputs for the current cycle.
  logic        expStartup, expReadOk, expWriteOk, expWe, expAcc, expErr;
  logic [2:0]  expSel;
  logic [31:0] expRData, expLast, expSlaveWData;
  logic [13:0] expSlaveAddr;
  logic [15:0] expTxn;

  int pinKind = 0;
  int pinN = 0;
  int total = 0;
  int bad = 0;

  task automatic computeExp();
    bit acc;
    if (inReset) begin
      expStartup = 0; expReadOk = 0; expWriteOk = 0; expWe = 0; expAcc = 0; expErr = 0;
      expSel = 0; expRData = 0; expLast = 0; expSlaveWData = 0; expSlaveAddr = 0; expTxn = 0;
    end else begin
      expStartup    = ((cyc - relCyc) >= SU);
      acc           = txActive && txMapped && (cyc > txN) && (cyc < txR);
      expAcc        = acc;
      expSel        = acc ? 3'(1 << txIdx) : 3'b000;
      expWe         = acc && txWr;
      expSlaveAddr  = txAddr[13:0];
      expSlaveWData = txWData;
      expReadOk     = txActive && (cyc == txR) && !txWr;
      expWriteOk    = txActive && (cyc == txR) && txWr;
      expRData      = mdlRData;
      expLast       = mdlLast;
      expTxn        = mdlTxn;
      expErr        = mdlErr;
    end
  endtask

  task automatic modelReset();
    inReset = 1; txActive = 0; pendCommit = 0;
    mdlRData = 0; mdlLast = 0; mdlTxn = 0; mdlErr = 0;
  endtask

  // Advance one cycle: drive inputs for it and update the model's view.
  task automatic stepCycle(input bit reqOn);
    logic [31:0] r;
    @(posedge CoreClock);
    cyc = cyc + 1;
    #1;
    if (pendCommit && cyc == pendCyc) begin
      mdlTxn = mdlTxn + 16'd1;
      if (pendErr) mdlErr = 1;
      pendCommit = 0;
    end
    CoreReq = reqOn;
    if (txActive && cyc == txN) begin
      CoreWrite = txWr; CoreAddress = txAddr; CoreWData = txWData;
    end else begin
      r = $urandom;
      CoreWrite = r[0]; CoreAddress = $urandom; CoreWData = $urandom;
    end
    r = $urandom;
    SlaveReady = r[2:0];
    for (int i = 0; i < NS; i++) SlaveRData[i*32 +: 32] = $urandom;
    if (txActive && txMapped && cyc > txN && cyc < txR) begin
      SlaveReady[txIdx] = (cyc == txReadyCyc);
      if (cyc == txReadyCyc) SlaveRData[txIdx*32 +: 32] = txData;
    end
    if (txActive && cyc == txN + 1) mdlLast = txAddr;
    if (txActive && cyc == txR) begin
      if (!txWr) mdlRData = txErr ? ERRD : txData;
      pendCommit = 1; pendCyc = cyc + 1; pendErr = txErr;
    end
    computeExp();
  endtask

  // One core access; k = ready delay in cycles, k >= TO means never ready.
  task automatic runTxn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int k, input logic [31:0] rdata, input int pk);
    txActive = 1; txN = cyc + 1; txWr = wr; txAddr = addr; txWData = wdata; txData = rdata;
    txIdx = int'(addr[15:14]);
    txMapped = (txIdx < NS);
    if (!txMapped) begin
      txR = txN + 1; txErr = 1; txReadyCyc = -1;
    end else if (k < TO) begin
      txR = txN + 2 + k; txErr = 0; txReadyCyc = txN + 1 + k;
    end else begin
      txR = txN + 1 + TO; txErr = 1; txReadyCyc = -1;
    end
    pinKind = pk; pinN = txN;
    txCount++;
    $display("txn %0d %s addr=%08h slave=%0d delay=%0d start=%0d ok_at=%0d",
             txCount, wr ? "WR" : "RD", addr, txIdx, k, txN, txR);
    while (cyc < txR) stepCycle(1'b1);
  endtask

  // Hold reset one more cycle, release it and run the startup window with CoreReq high.
  task automatic bootSeq();
    stepCycle(1'b1);
    ResetN = 1; relCyc = cyc; inReset = 0; pinKind = 1; pinN = cyc;
    computeExp();
    repeat (SU - 1) stepCycle(1'b1);
    stepCycle(1'b0);
  endtask

  task automatic randomTxns(input int n);
    logic [31:0] a;
    int r, k;
    for (int t = 0; t < n; t++) begin
      a = $urandom;
      a[15:14] = 2'($urandom_range(0, 3));
      r = $urandom_range(0, 9);
      if (r <= 4) k = r;
      else if (r == 5) k = TO - 1;
      else if (r == 6) k = TO + 2;
      else k = $urandom_range(0, 2);
      runTxn(1'($urandom_range(0, 1)), a, $urandom, k, $urandom, 0);
      repeat ($urandom_range(0, 2)) stepCycle(1'b0);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, want);
    end
  endtask

  // Compare process: model check every cycle plus hand-computed pins.
  always @(negedge CoreClock) begin
    chk("StartupDone", 32'(StartupDone), 32'(expStartup));
    chk("SlaveSel", 32'(SlaveSel), 32'(expSel));
    chk("SlaveWe", 32'(SlaveWe), 32'(expWe));
    chk("CoreReadOK", 32'(CoreReadOK), 32'(expReadOk));
    chk("CoreWriteOK", 32'(CoreWriteOK), 32'(expWriteOk));
    chk("CoreRData", CoreRData, expRData);
    chk("LastAddress", LastAddress, expLast);
    chk("TxnCount", 32'(TxnCount), 32'(expTxn));
    chk("ErrorFlag", 32'(ErrorFlag), 32'(expErr));
    if (expAcc) begin
      chk("SlaveAddr", 32'(SlaveAddr), 32'(expSlaveAddr));
      chk("SlaveWData", SlaveWData, expSlaveWData);
    end
    case (pinKind)
      1: begin
        if (cyc == pinN + SU - 1) chk("pin_boot_lo", 32'(StartupDone), 32'd0);
        if (cyc == pinN + SU)     chk("pin_boot_hi", 32'(StartupDone), 32'd1);
      end
      2: begin
        if (cyc == pinN + 1) begin
          chk("pin_wr_sel", 32'(SlaveSel), 32'b010);
          chk("pin_wr_we", 32'(SlaveWe), 32'd1);
          chk("pin_wr_addr", 32'(SlaveAddr), 32'h0010);
          chk("pin_wr_data", SlaveWData, 32'h1234_5678);
        end
        if (cyc == pinN + 2) chk("pin_wr_ok", 32'(CoreWriteOK), 32'd1);
        if (cyc == pinN + 3) chk("pin_wr_txn", 32'(TxnCount), 32'd1);
      end
      3: begin
        if (cyc == pinN + 4) chk("pin_rd_early", 32'(CoreReadOK), 32'd0);
        if (cyc == pinN + 5) begin
          chk("pin_rd_ok", 32'(CoreReadOK), 32'd1);
          chk("pin_rd_data", CoreRData, 32'hCAFE_0001);
        end
      end
      7: begin
        if (cyc == pinN + 2) begin
          chk("pin_hold_ok", 32'(CoreWriteOK), 32'd1);
          chk("pin_hold_data", CoreRData, 32'hCAFE_0001);
        end
      end
      5: begin
        if (cyc == pinN + 8) begin
          chk("pin_to_sel", 32'(SlaveSel), 32'b001);
          chk("pin_to_early", 32'(CoreReadOK), 32'd0);
        end
        if (cyc == pinN + 9) begin
          chk("pin_to_ok", 32'(CoreReadOK), 32'd1);
          chk("pin_to_data", CoreRData, 32'hDEAD_BEEF);
          chk("pin_to_err0", 32'(ErrorFlag), 32'd0);
        end
        if (cyc == pinN + 10) chk("pin_to_err1", 32'(ErrorFlag), 32'd1);
      end
      4: begin
        if (cyc == pinN + 1) begin
          chk("pin_um_sel", 32'(SlaveSel), 32'd0);
          chk("pin_um_ok", 32'(CoreReadOK), 32'd1);
          chk("pin_um_data", CoreRData, 32'hDEAD_BEEF);
        end
        if (cyc == pinN + 2) chk("pin_um_txn", 32'(TxnCount), 32'd6);
      end
      6: begin
        if (cyc == pinN) begin
          chk("pin_rst_sel", 32'(SlaveSel), 32'd0);
          chk("pin_rst_ok", 32'(CoreReadOK), 32'd0);
          chk("pin_rst_txn", 32'(TxnCount), 32'd0);
          chk("pin_rst_boot", 32'(StartupDone), 32'd0);
        end
      end
      default: ;
    endcase
  end

  initial begin
    ResetN = 0; CoreReq = 0; CoreWrite = 0; CoreAddress = 0; CoreWData = 0;
    SlaveRData = '0; SlaveReady = '0; txCount = 0;
    modelReset();
    computeExp();
    repeat (3) stepCycle(1'b1);
    bootSeq();
    repeat (2) stepCycle(1'b0);

    // Directed accesses from the datasheet examples.
    runTxn(1'b1, 32'h0000_4010, 32'h1234_5678, 0, 32'h0, 2);
    repeat (2) stepCycle(1'b0);
    runTxn(1'b0, 32'h0000_0008, 32'h0, 3, 32'hCAFE_0001, 3);
    stepCycle(1'b0);
    runTxn(1'b1, 32'h0000_8004, 32'h5555_AAAA, 0, 32'h0, 7);
    repeat (2) stepCycle(1'b0);
    runTxn(1'b0, 32'h0000_0020, 32'h0, TO + 5, 32'h0, 5);
    repeat (2) stepCycle(1'b0);
    runTxn(1'b0, 32'h0000_4444, 32'h0, 1, 32'h0BAD_F00D, 0);
    stepCycle(1'b0);
    runTxn(1'b0, 32'h0000_C000, 32'h0, 0, 32'h0, 4);
    repeat (2) stepCycle(1'b0);

    randomTxns(150);

    // Reset in the middle of an access that would otherwise time out.
    txActive = 1; txN = cyc + 1; txWr = 0; txAddr = 32'h0000_0100; txWData = 0; txData = 0;
    txIdx = 0; txMapped = 1; txR = txN + 1 + TO; txErr = 1; txReadyCyc = -1;
    repeat (3) stepCycle(1'b1);
    #2;
    ResetN = 0;
    modelReset();
    computeExp();
    pinKind = 6; pinN = cyc;
    repeat (3) stepCycle(1'b0);
    bootSeq();
    repeat (2) stepCycle(1'b0);

    randomTxns(60);
    repeat (3) stepCycle(1'b0);

    @(negedge CoreClock);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
